// File: rtl/flash_op_sequencer_if.sv
// Bus bundle between the macro FSM, the flash op sequencer and the QSPI byte engine.
// master = sequencer side, slave = macro FSM / SPI engine side.
interface flash_op_sequencer_if;
    logic [3:0]  macro_states;
    logic        macro_states_valid;
    logic [31:0] addr_reg;
    logic        flash_macro_states_done;
    logic        flash_busy;
    logic        flash_error;
    logic [7:0]  status_byte;
    logic [7:0]  spi_cmd;
    logic [31:0] spi_addr;
    logic        spi_addr_en;
    logic [8:0]  spi_len;
    logic        spi_req;
    logic        spi_done;
    logic [7:0]  spi_rd_byte;

    modport master (
        input  macro_states, macro_states_valid, addr_reg, spi_done, spi_rd_byte,
        output flash_macro_states_done, flash_busy, flash_error, status_byte,
               spi_cmd, spi_addr, spi_addr_en, spi_len, spi_req
    );

    modport slave (
        output macro_states, macro_states_valid, addr_reg, spi_done, spi_rd_byte,
        input  flash_macro_states_done, flash_busy, flash_error, status_byte,
               spi_cmd, spi_addr, spi_addr_en, spi_len, spi_req
    );
endinterface

// File: rtl/flash_op_sequencer.sv
// Turns one flash macro command into SPI transactions: optional WREN preamble,
// the command itself, then RDSR busy polling for program/erase.
module flash_op_sequencer #(
    parameter int unsigned POLL_GAP = 64,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    flash_op_sequencer_if.master  bus
);
    localparam int unsigned GAP_W   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [7:0]  OP_WREN = 8'h06;
    localparam logic [7:0]  OP_RDSR = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_WT_WREN, S_OP, S_WT_OP, S_GAP, S_RDSR, S_WT_RDSR, S_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [3:0]        r_code;
    logic [31:0]       r_addr;
    logic [23:0]       r_poll;
    logic [GAP_W-1:0]  r_gap;
    logic              r_done, r_busy, r_error, r_req, r_addr_en;
    logic [7:0]        r_status, r_cmd;
    logic [31:0]       r_spi_addr;
    logic [8:0]        r_len;

    logic [3:0]        w_code;
    logic [31:0]       w_addr;
    logic              w_accept;
    logic [7:0]        w_dec_op;
    logic              w_dec_aen, w_dec_wren, w_dec_poll;
    logic [8:0]        w_dec_len;
    logic              w_issue, w_aen, w_load_addr, w_capture;
    logic              w_gap_clr, w_poll_clr, w_poll_inc, w_set_err;
    logic [7:0]        w_cmd;
    logic [8:0]        w_len;

    // Codes 0-9 belong to the UART path; busy (incl. the done cycle) blocks new strobes.
    assign w_accept = (r_state == S_IDLE) && !r_busy && bus.macro_states_valid
                      && (bus.macro_states >= 4'hA);
    assign w_code   = (r_state == S_IDLE) ? bus.macro_states : r_code;
    assign w_addr   = w_accept ? bus.addr_reg : r_addr;

    always_comb begin
        w_dec_op   = 8'h00;
        w_dec_aen  = 1'b0;
        w_dec_len  = 9'd0;
        w_dec_wren = 1'b0;
        w_dec_poll = 1'b0;
        case (w_code)
            4'hA: begin w_dec_op = 8'h20; w_dec_aen = 1'b1; w_dec_wren = 1'b1; w_dec_poll = 1'b1; end
            4'hB: begin w_dec_op = 8'h9F; w_dec_len = 9'd3; end
            4'hC: begin w_dec_op = 8'h02; w_dec_aen = 1'b1; w_dec_len = 9'd256;
                        w_dec_wren = 1'b1; w_dec_poll = 1'b1; end
            4'hD: begin w_dec_op = 8'h03; w_dec_aen = 1'b1; w_dec_len = 9'd256; end
            4'hE: begin w_dec_op = 8'h05; w_dec_len = 9'd1; end
            4'hF: begin w_dec_op = 8'h48; w_dec_len = 9'd1; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_cmd        = r_cmd;
        w_aen        = r_addr_en;
        w_len        = r_len;
        w_load_addr  = 1'b0;
        w_capture    = 1'b0;
        w_gap_clr    = 1'b0;
        w_poll_clr   = 1'b0;
        w_poll_inc   = 1'b0;
        w_set_err    = 1'b0;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_next = w_dec_wren ? S_WREN : S_OP;
            S_WREN:    w_state_next = S_WT_WREN;
            S_WT_WREN: if (bus.spi_done) w_state_next = S_OP;
            S_OP:      w_state_next = S_WT_OP;
            S_WT_OP: begin
                if (bus.spi_done) begin
                    w_capture = 1'b1;
                    if (w_dec_poll) begin
                        w_poll_clr   = 1'b1;
                        w_gap_clr    = 1'b1;
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_GAP:     if (r_gap == GAP_W'(POLL_GAP - 1)) w_state_next = S_RDSR;
            S_RDSR: begin
                w_poll_inc   = 1'b1;
                w_state_next = S_WT_RDSR;
            end
            S_WT_RDSR: begin
                if (bus.spi_done) begin
                    w_capture = 1'b1;
                    if (!bus.spi_rd_byte[0]) begin
                        w_state_next = S_DONE;
                    end else if (r_poll == POLL_MAX) begin
                        w_set_err    = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_gap_clr    = 1'b1;
                        w_state_next = S_GAP;
                    end
                end
            end
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase

        // Request fields are loaded on entry so they are valid with the spi_req pulse.
        case (w_state_next)
            S_WREN: begin w_issue = 1'b1; w_cmd = OP_WREN; w_aen = 1'b0; w_len = 9'd0; end
            S_OP:   begin w_issue = 1'b1; w_cmd = w_dec_op; w_aen = w_dec_aen; w_len = w_dec_len;
                          w_load_addr = 1'b1; end
            S_RDSR: begin w_issue = 1'b1; w_cmd = OP_RDSR; w_aen = 1'b0; w_len = 9'd1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_code     <= 4'h0;
            r_addr     <= 32'h0;
            r_poll     <= 24'h0;
            r_gap      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_req      <= 1'b0;
            r_addr_en  <= 1'b0;
            r_status   <= 8'h00;
            r_cmd      <= 8'h00;
            r_spi_addr <= 32'h0;
            r_len      <= 9'd0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_issue;
            r_done  <= (r_state == S_DONE);
            if (w_issue) begin
                r_cmd     <= w_cmd;
                r_addr_en <= w_aen;
                r_len     <= w_len;
            end
            if (w_load_addr) r_spi_addr <= w_addr;
            if (w_accept) begin
                r_code <= bus.macro_states;
                r_addr <= bus.addr_reg;
            end
            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;
            if (w_accept)       r_error <= 1'b0;
            else if (w_set_err) r_error <= 1'b1;
            if (w_capture) r_status <= bus.spi_rd_byte;
            if (w_gap_clr)              r_gap <= '0;
            else if (r_state == S_GAP)  r_gap <= r_gap + 1'b1;
            if (w_poll_clr)                            r_poll <= 24'h0;
            else if (w_poll_inc && r_poll != POLL_MAX) r_poll <= r_poll + 24'd1;
        end
    end

    assign bus.flash_macro_states_done = r_done;
    assign bus.flash_busy              = r_busy;
    assign bus.flash_error             = r_error;
    assign bus.status_byte             = r_status;
    assign bus.spi_cmd                 = r_cmd;
    assign bus.spi_addr                = r_spi_addr;
    assign bus.spi_addr_en             = r_addr_en;
    assign bus.spi_len                 = r_len;
    assign bus.spi_req                 = r_req;
endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a small SPI engine responder model.
module tb_flash_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;

    logic [7:0]  rsp_q[$];
    logic [7:0]  log_cmd[$];
    logic [31:0] log_addr[$];
    logic        log_aen[$];
    logic [8:0]  log_len[$];
    int          log_req_cyc[$];
    int          log_done_cyc[$];

    flash_op_sequencer_if ifc();

    flash_op_sequencer #(.POLL_GAP(8), .POLL_MAX(24'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (ifc.flash_macro_states_done === 1'b1) done_cnt++;

    // SPI engine model: logs each request, answers with spi_done two cycles later.
    initial begin : responder
        ifc.spi_done    = 1'b0;
        ifc.spi_rd_byte = 8'h00;
        forever begin
            @(negedge clk);
            ifc.spi_done = 1'b0;
            if (ifc.spi_req === 1'b1 && !rst) begin
                log_cmd.push_back(ifc.spi_cmd);
                log_addr.push_back(ifc.spi_addr);
                log_aen.push_back(ifc.spi_addr_en);
                log_len.push_back(ifc.spi_len);
                log_req_cyc.push_back(cyc);
                @(negedge clk);
                @(negedge clk);
                if (!rst) begin
                    ifc.spi_rd_byte = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
                    ifc.spi_done    = 1'b1;
                    log_done_cyc.push_back(cyc);
                    last_done_cyc   = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  32'(ifc.flash_macro_states_done), 32'h0);
        check({tag, "_busy"},  32'(ifc.flash_busy),  32'h0);
        check({tag, "_err"},   32'(ifc.flash_error), 32'h0);
        check({tag, "_stat"},  32'(ifc.status_byte), 32'h0);
        check({tag, "_cmd"},   32'(ifc.spi_cmd),     32'h0);
        check({tag, "_addr"},  ifc.spi_addr,         32'h0);
        check({tag, "_aen"},   32'(ifc.spi_addr_en), 32'h0);
        check({tag, "_len"},   32'(ifc.spi_len),     32'h0);
        check({tag, "_req"},   32'(ifc.spi_req),     32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the strobe cycle.
    task automatic strobe(input logic [3:0] code, input logic [31:0] addr);
        ifc.macro_states       = code;
        ifc.addr_reg           = addr;
        ifc.macro_states_valid = 1'b1;
        @(negedge clk);
        ifc.macro_states_valid = 1'b0;
    endtask

    // Returns at the negedge where the done pulse is visible.
    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (ifc.flash_macro_states_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int base;
        int dc;
        int n_rdsr;
        ifc.macro_states       = 4'h0;
        ifc.addr_reg           = 32'h0;
        ifc.macro_states_valid = 1'b0;

        // Reset
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // RdSR: single read, no WREN, no polling
        rsp_q.delete();
        rsp_q.push_back(8'h5A);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hE, 32'h0000_0000);
        check("rdsr_busy", 32'(ifc.flash_busy), 32'h1);
        check("rdsr_req",  32'(ifc.spi_req),    32'h1);
        check("rdsr_cmd",  32'(ifc.spi_cmd),    32'h05);
        check("rdsr_len",  32'(ifc.spi_len),    32'd1);
        wait_done("rdsr", 100);
        check("rdsr_done_lat", 32'(cyc - last_done_cyc), 32'd2);
        check("rdsr_status",   32'(ifc.status_byte),     32'h5A);
        check("rdsr_err",      32'(ifc.flash_error),     32'h0);
        idle(1);
        check("rdsr_done_width", 32'(ifc.flash_macro_states_done), 32'h0);
        idle(1);
        check("rdsr_busy_drop",  32'(ifc.flash_busy), 32'h0);
        check("rdsr_nreq",       32'(log_cmd.size() - base), 32'd1);
        check("rdsr_ndone",      32'(done_cnt - dc), 32'd1);

        // WrPg: WREN, program, WIP=1 twice then 0
        rsp_q.delete();
        rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
        rsp_q.push_back(8'h01); rsp_q.push_back(8'h01); rsp_q.push_back(8'h00);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hC, 32'h0001_2300);
        wait_done("wrpg", 300);
        check("wrpg_done_lat", 32'(cyc - last_done_cyc), 32'd2);
        check("wrpg_err",      32'(ifc.flash_error),     32'h0);
        idle(30);
        check("wrpg_nreq",  32'(log_cmd.size() - base), 32'd5);
        check("wrpg_ndone", 32'(done_cnt - dc),          32'd1);
        if (log_cmd.size() - base == 5) begin
            check("wrpg_c0",   32'(log_cmd[base]),     32'h06);
            check("wrpg_aen0", 32'(log_aen[base]),     32'h0);
            check("wrpg_len0", 32'(log_len[base]),     32'd0);
            check("wrpg_c1",   32'(log_cmd[base+1]),   32'h02);
            check("wrpg_a1",   log_addr[base+1],       32'h0001_2300);
            check("wrpg_aen1", 32'(log_aen[base+1]),   32'h1);
            check("wrpg_len1", 32'(log_len[base+1]),   32'd256);
            for (int k = 2; k < 5; k++) begin
                check("wrpg_cpoll",   32'(log_cmd[base+k]), 32'h05);
                check("wrpg_lenpoll", 32'(log_len[base+k]), 32'd1);
            end
            for (int k = 1; k < 4; k++)
                check("wrpg_gap_ge9",
                      32'((log_req_cyc[base+k+1] - log_done_cyc[base+k]) >= 9), 32'h1);
        end

        // Timeout: erase with WIP stuck at 1, POLL_MAX=4
        rsp_q.delete();
        rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
        for (int k = 0; k < 6; k++) rsp_q.push_back(8'h01);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hA, 32'h0000_4000);
        wait_done("tmo", 400);
        check("tmo_err",    32'(ifc.flash_error), 32'h1);
        check("tmo_status", 32'(ifc.status_byte), 32'h01);
        idle(30);
        check("tmo_err_held", 32'(ifc.flash_error),       32'h1);
        check("tmo_nreq",     32'(log_cmd.size() - base), 32'd6);
        check("tmo_ndone",    32'(done_cnt - dc),         32'd1);
        n_rdsr = 0;
        for (int k = base; k < log_cmd.size(); k++)
            if (log_cmd[k] == 8'h05) n_rdsr++;
        check("tmo_nrdsr", 32'(n_rdsr), 32'd4);
        if (log_cmd.size() - base == 6) begin
            check("tmo_c1", 32'(log_cmd[base+1]), 32'h20);
            check("tmo_a1", log_addr[base+1],     32'h0000_4000);
            for (int k = 1; k < 5; k++)
                check("tmo_gap_ge9",
                      32'((log_req_cyc[base+k+1] - log_done_cyc[base+k]) >= 9), 32'h1);
        end

        // UART codes 0-9 are ignored
        rsp_q.delete();
        base = log_cmd.size();
        dc   = done_cnt;
        for (int c = 0; c < 10; c++) strobe(4'(c), 32'h0000_0100);
        idle(10);
        check("uart_nreq",  32'(log_cmd.size() - base), 32'd0);
        check("uart_ndone", 32'(done_cnt - dc),          32'd0);
        check("uart_busy",  32'(ifc.flash_busy),         32'h0);

        // RdPg with a second strobe while busy and a strobe in the done cycle
        rsp_q.delete();
        rsp_q.push_back(8'hA5);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hD, 32'h0000_0100);
        check("rdpg_err_clr", 32'(ifc.flash_error), 32'h0);
        strobe(4'hD, 32'h0000_0200);
        wait_done("rdpg", 100);
        check("rdpg_busy_at_done", 32'(ifc.flash_busy), 32'h1);
        ifc.macro_states       = 4'hE;
        ifc.macro_states_valid = 1'b1;
        @(negedge clk);
        ifc.macro_states_valid = 1'b0;
        idle(10);
        check("rdpg_status", 32'(ifc.status_byte),     32'hA5);
        check("rdpg_nreq",   32'(log_cmd.size() - base), 32'd1);
        check("rdpg_ndone",  32'(done_cnt - dc),         32'd1);
        if (log_cmd.size() - base == 1) begin
            check("rdpg_cmd",  32'(log_cmd[base]), 32'h03);
            check("rdpg_addr", log_addr[base],     32'h0000_0100);
            check("rdpg_aen",  32'(log_aen[base]), 32'h1);
            check("rdpg_len",  32'(log_len[base]), 32'd256);
        end

        // Reset while in the poll gap aborts without a done pulse
        rsp_q.delete();
        rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hA, 32'h0000_8000);
        idle(7);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstmid");
        rst = 1'b0;
        idle(30);
        check("rstmid_ndone", 32'(done_cnt - dc),          32'd0);
        check("rstmid_nreq",  32'(log_cmd.size() - base), 32'd2);
        check("rstmid_busy",  32'(ifc.flash_busy),         32'h0);

        // RdID after the aborted command runs normally
        rsp_q.delete();
        rsp_q.push_back(8'h17);
        base = log_cmd.size();
        dc   = done_cnt;
        strobe(4'hB, 32'h0000_0000);
        check("rdid_req", 32'(ifc.spi_req),     32'h1);
        check("rdid_cmd", 32'(ifc.spi_cmd),     32'h9F);
        check("rdid_len", 32'(ifc.spi_len),     32'd3);
        check("rdid_aen", 32'(ifc.spi_addr_en), 32'h0);
        wait_done("rdid", 100);
        check("rdid_status", 32'(ifc.status_byte), 32'h17);
        check("rdid_err",    32'(ifc.flash_error), 32'h0);
        idle(5);
        check("rdid_nreq",  32'(log_cmd.size() - base), 32'd1);
        check("rdid_ndone", 32'(done_cnt - dc),          32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
